apb_mem_slave_p: RTL and testbench



---
 rtl/apb_mem_pkg.sv | 21 ++
 rtl/apb_mem_array.sv | 46 ++++
 rtl/apb_mem_slave_p.sv | 162 ++++++++++++++++
 tb/tb_apb_mem_slave_p.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared types and helpers for the apb_mem_slave_p memory slave.
package apb_mem_pkg;

  // Transfer FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StAbort
  } state_e;

  // Error cause captured at setup; anything other than ErrNone reports pslverr.
  localparam logic [1:0] ErrNone   = 2'd0;
  localparam logic [1:0] ErrDecode = 2'd1;
  localparam logic [1:0] ErrProt   = 2'd2;

  // Byte-offset shift for one data word: log2 of the byte-lane count.
  function automatic int unsigned lane_shift(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array: DEPTH x DATA_W storage with per-byte write enable, registered read
// and synchronous clear on prst_i.
module apb_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128
) (
  input  logic                     pclk_i,
  input  logic                     prst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [DATA_W/8-1:0]      wstrb_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  localparam int unsigned StrbW = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage, byte-lane writes and the read buffer; reset clears every word.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        for (int unsigned b = 0; b < StrbW; b++) begin
          if (wstrb_i[b]) begin
            mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p: parametrised APB4 memory slave with wait states, byte strobes,
// aligned address decode and one-cycle protocol-violation pulses.
// Optional feature macro APB_MEM_SLAVE_PROT_EN: adds pprot_i; unprivileged writes
// (pprot_i[0]=0) complete with pslverr_o=1 and leave memory untouched.
module apb_mem_slave_p
  import apb_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [DATA_W/8-1:0] pstrb_i,
`ifdef APB_MEM_SLAVE_PROT_EN
  input  logic [2:0]          pprot_i,
`endif
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  output logic                proto_err_o
);

  localparam int unsigned       Shift     = lane_shift(DATA_W);
  localparam int unsigned       IdxW      = $clog2(DEPTH);
  localparam int unsigned       StrbW     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'((1 << Shift) - 1);
  localparam logic [3:0]        WaitCnt   = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [IdxW-1:0]     idx_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [StrbW-1:0]    strb_q;
  logic [1:0]          cause_q, cause;
  logic                idle_viol_q, idle_viol_d;

  logic [ADDR_W-1:0]   offset, word;
  logic [IdxW-1:0]     raddr;
  logic                dec_err, priv, capture, mem_we, mem_re, ready, err;
  logic [DATA_W-1:0]   rdata;

  // Address decode relative to BASE_ADDR; offset wraps for addresses below base,
  // so the explicit below-base compare catches those.
  assign offset  = paddr_i - BASE_ADDR;
  assign word    = offset >> Shift;
  assign raddr   = word[IdxW-1:0];
  assign dec_err = (paddr_i < BASE_ADDR) || (word >= ADDR_W'(DEPTH)) ||
                   ((offset & AlignMask) != '0);

`ifdef APB_MEM_SLAVE_PROT_EN
  logic unused_prot;
  assign unused_prot = ^pprot_i[2:1];
  assign priv        = pprot_i[0];
`else
  assign priv = 1'b1;
`endif

  // Error cause for the transfer being set up; decode errors take precedence.
  always_comb begin
    cause = ErrNone;
    if (dec_err) begin
      cause = ErrDecode;
    end else if (pwrite_i && !priv) begin
      cause = ErrProt;
    end
  end

  // Next-state, wait counter and memory strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    idle_viol_d = 1'b0;
    ready       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel_i && !penable_i) begin
          capture = 1'b1;
          mem_re  = !pwrite_i && !dec_err;
          cnt_d   = '0;
          state_d = StAccess;
        end else if (psel_i && penable_i) begin
          idle_viol_d = 1'b1;
        end
      end
      StAccess: begin
        ready = (cnt_q == WaitCnt);
        if (!psel_i || (paddr_i != addr_q) || (pwrite_i != write_q)) begin
          state_d = StAbort;
        end else if (penable_i && ready) begin
          mem_we  = write_q && (cause_q == ErrNone);
          state_d = StIdle;
        end else if (!ready) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register and setup-phase capture of the transfer attributes.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      cause_q     <= ErrNone;
      idle_viol_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_viol_q <= idle_viol_d;
      if (capture) begin
        addr_q  <= paddr_i;
        idx_q   <= raddr;
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
        strb_q  <= pstrb_i;
        cause_q <= cause;
      end
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .pclk_i  (pclk_i),
    .prst_i  (prst_i),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .re_i    (mem_re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign err         = (cause_q != ErrNone);
  assign pready_o    = ready;
  assign pslverr_o   = ready && err;
  assign prdata_o    = (ready && !write_q && !err) ? rdata : '0;
  assign proto_err_o = (state_q == StAbort) || idle_viol_q;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Directed bench for apb_mem_slave_p. Three instances share one bus: index 0 has no
// wait states, index 1 has three, index 2 has two. Each test targets one instance;
// the others see a protocol-odd bus and are not checked while untargeted.
module tb_apb_mem_slave_p;

  logic              pclk = 1'b0;
  logic              prst;
  logic              psel, penable, pwrite;
  logic [31:0]       paddr, pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [2:0][31:0]  prdata;
  logic [2:0]        pready, pslverr, proto_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        err;
  int          cyc;

  initial forever #5 pclk = ~pclk;

  apb_mem_slave_p #(.WAIT_STATES(0)) u_ws0 (
    .pclk_i(pclk), .prst_i(prst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
`ifdef APB_MEM_SLAVE_PROT_EN
    .pprot_i(pprot),
`endif
    .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]),
    .proto_err_o(proto_err[0])
  );

  apb_mem_slave_p #(.WAIT_STATES(3)) u_ws3 (
    .pclk_i(pclk), .prst_i(prst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
`ifdef APB_MEM_SLAVE_PROT_EN
    .pprot_i(pprot),
`endif
    .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]),
    .proto_err_o(proto_err[1])
  );

  apb_mem_slave_p #(.WAIT_STATES(2)) u_ws2 (
    .pclk_i(pclk), .prst_i(prst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
`ifdef APB_MEM_SLAVE_PROT_EN
    .pprot_i(pprot),
`endif
    .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]),
    .proto_err_o(proto_err[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic e, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] st);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d; pstrb = st;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // One complete transfer to instance sel; acc returns the number of ACCESS cycles.
  task automatic xfer(input int sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdat, output logic serr, output int acc);
    int n;
    @(posedge pclk); #1;
    drive(1'b1, 1'b0, wr, addr, wdata, strb);
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 1;
    @(negedge pclk);
    while (!pready[sel] && n < 20) begin
      @(negedge pclk);
      n++;
    end
    rdat = prdata[sel];
    serr = pslverr[sel];
    acc  = n;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    prst  = 1'b1;
    pprot = 3'b001;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;
    @(negedge pclk);

    // Reset state.
    check("rst_pready", pready[0], 0);
    check("rst_pslverr", pslverr[0], 0);
    check("rst_prdata", prdata[0], 0);
    check("rst_proto_err", proto_err[0], 0);
    xfer(0, 1'b0, 32'h1000_01FC, 32'h0, 4'h0, rd, err, cyc);
    check("rst_mem_last_word", rd, 0);
    check("last_word_slverr", err, 0);

    // Basic write/read with no wait states.
    xfer(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, rd, err, cyc);
    check("wr_cycles", cyc, 1);
    check("wr_slverr", err, 0);
    xfer(0, 1'b0, 32'h1000_0010, 32'h0, 4'h0, rd, err, cyc);
    check("rd_cycles", cyc, 1);
    check("rd_slverr", err, 0);
    check("rd_data", rd, 32'hDEAD_BEEF);

    // Partial byte strobes.
    xfer(0, 1'b1, 32'h1000_0014, 32'h1122_3344, 4'hF, rd, err, cyc);
    xfer(0, 1'b1, 32'h1000_0014, 32'hAABB_CCDD, 4'b0101, rd, err, cyc);
    xfer(0, 1'b0, 32'h1000_0014, 32'h0, 4'h0, rd, err, cyc);
    check("strb_merge", rd, 32'h11BB_33DD);

    // First word.
    xfer(0, 1'b1, 32'h1000_0000, 32'h0102_0304, 4'hF, rd, err, cyc);
    xfer(0, 1'b0, 32'h1000_0000, 32'h0, 4'h0, rd, err, cyc);
    check("first_word", rd, 32'h0102_0304);

    // Decode errors: below base, past end, misaligned.
    xfer(0, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0, rd, err, cyc);
    check("below_base_slverr", err, 1);
    check("below_base_data", rd, 0);
    xfer(0, 1'b0, 32'h1000_0200, 32'h0, 4'h0, rd, err, cyc);
    check("past_end_slverr", err, 1);
    check("past_end_data", rd, 0);
    xfer(0, 1'b0, 32'h1000_0002, 32'h0, 4'h0, rd, err, cyc);
    check("misalign_slverr", err, 1);
    check("misalign_data", rd, 0);
    xfer(0, 1'b1, 32'h1000_0012, 32'h0, 4'hF, rd, err, cyc);
    check("misalign_wr_slverr", err, 1);
    xfer(0, 1'b0, 32'h1000_0010, 32'h0, 4'h0, rd, err, cyc);
    check("misalign_wr_no_update", rd, 32'hDEAD_BEEF);

    // psel dropped during ACCESS.
    @(posedge pclk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'h1000_0020, 32'h1234_5678, 4'hF);
    @(posedge pclk); #1;
    psel = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("psel_drop_pulse", proto_err[0], 1);
    check("psel_drop_pready", pready[0], 0);
    @(negedge pclk);
    check("psel_drop_clear", proto_err[0], 0);

    // Access phase without setup.
    @(posedge pclk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'h0);
    @(negedge pclk);
    check("no_setup_before", proto_err[0], 0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("no_setup_pulse", proto_err[0], 1);
    check("no_setup_pready", pready[0], 0);
    @(negedge pclk);
    check("no_setup_clear", proto_err[0], 0);

    // paddr changed during ACCESS.
    @(posedge pclk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'h1000_0024, 32'h0000_9999, 4'hF);
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = 32'h1000_0028;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("addr_chg_pulse", proto_err[0], 1);
    check("addr_chg_pready", pready[0], 0);
    @(negedge pclk);
    check("addr_chg_clear", proto_err[0], 0);
    xfer(0, 1'b0, 32'h1000_0020, 32'h0, 4'h0, rd, err, cyc);
    check("psel_drop_no_write", rd, 0);
    xfer(0, 1'b0, 32'h1000_0024, 32'h0, 4'h0, rd, err, cyc);
    check("addr_chg_no_write_a", rd, 0);
    xfer(0, 1'b0, 32'h1000_0028, 32'h0, 4'h0, rd, err, cyc);
    check("addr_chg_no_write_b", rd, 0);

`ifdef APB_MEM_SLAVE_PROT_EN
    // Unprivileged write is refused; unprivileged read is served.
    pprot = 3'b000;
    xfer(0, 1'b1, 32'h1000_0010, 32'h0000_0000, 4'hF, rd, err, cyc);
    check("prot_wr_slverr", err, 1);
    xfer(0, 1'b0, 32'h1000_0010, 32'h0, 4'h0, rd, err, cyc);
    check("prot_rd_slverr", err, 0);
    check("prot_no_update", rd, 32'hDEAD_BEEF);
    pprot = 3'b001;
`endif

    // Three wait states.
    idle(3);
    xfer(1, 1'b1, 32'h1000_0030, 32'hCAFE_F00D, 4'hF, rd, err, cyc);
    check("ws3_wr_cycles", cyc, 4);
    check("ws3_wr_slverr", err, 0);
    idle(3);
    xfer(1, 1'b0, 32'h1000_0030, 32'h0, 4'h0, rd, err, cyc);
    check("ws3_rd_cycles", cyc, 4);
    check("ws3_rd_data", rd, 32'hCAFE_F00D);

    // Reset in the middle of a two-wait-state write.
    idle(3);
    @(posedge pclk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'h1000_0040, 32'h55AA_55AA, 4'hF);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("ws2_wait_pready", pready[2], 0);
    prst = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("midrst_pready", pready[2], 0);
    check("midrst_pslverr", pslverr[2], 0);
    check("midrst_prdata", prdata[2], 0);
    check("midrst_proto_err", proto_err[2], 0);
    prst = 1'b0;
    xfer(2, 1'b0, 32'h1000_0040, 32'h0, 4'h0, rd, err, cyc);
    check("midrst_rd_cycles", cyc, 3);
    check("midrst_word_zero", rd, 0);
    idle(3);
    xfer(2, 1'b1, 32'h1000_0040, 32'h0BAD_F00D, 4'hF, rd, err, cyc);
    check("post_rst_wr_cycles", cyc, 3);
    idle(3);
    xfer(2, 1'b0, 32'h1000_0040, 32'h0, 4'h0, rd, err, cyc);
    check("post_rst_rd_data", rd, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
